// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: constants and types shared by the ID->EX issue stage.
// Contents: ALU control codes, MIPS-I opcode/funct values, operand-B select
// encoding, shift-amount / extension selectors and the EX register record.
package mips_alu_pkg;

  // ALU control codes seen by the EX-stage ALU
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_ADDU = 4'b1000;
  localparam logic [3:0] ALU_SUBU = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_LUI  = 4'b1110;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Operand-B select
  localparam logic SRCB_REG = 1'b0;
  localparam logic SRCB_IMM = 1'b1;

  // Shift-amount source
  localparam logic [1:0] SHMT_NONE  = 2'd0;
  localparam logic [1:0] SHMT_INSTR = 2'd1;
  localparam logic [1:0] SHMT_BUSA  = 2'd2;

  // Immediate extension
  localparam logic EXT_SIGN = 1'b0;
  localparam logic EXT_ZERO = 1'b1;

  // EX register contents; all-zero is the bubble / reset value
  typedef struct packed {
    logic [31:0] busa;
    logic [31:0] busb;
    logic [31:0] shift;
    logic [3:0]  alu_ctrl;
    logic [4:0]  shmt;
    logic        reg_write;
    logic [4:0]  dest;
    logic        alu_src_b;
    logic        valid;
    logic        illegal;
  } ex_reg_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational instruction decode for the ALU issue stage.
// Ports:
//   instr      in  32  instruction word
//   alu_ctrl   out 4   ALU operation code
//   shmt_sel   out 2   shift amount source (none / instr[10:6] / BusA[4:0])
//   alu_src_b  out 1   1 = immediate onto operand B
//   reg_write  out 1   result is written back
//   dest       out 5   destination register
//   ext_sel    out 1   immediate extension (sign / zero)
//   illegal    out 1   unsupported opcode or funct
module alu_ctrl_decode
  import mips_alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_ctrl,
  output logic [1:0]  shmt_sel,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic [4:0]  dest,
  output logic        ext_sel,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_fields;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  // rs is consumed as BusA by the register file, shamt/imm by the top level
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    alu_ctrl  = ALU_AND;
    shmt_sel  = SHMT_NONE;
    alu_src_b = SRCB_REG;
    reg_write = 1'b0;
    dest      = 5'd0;
    ext_sel   = EXT_SIGN;
    illegal   = 1'b0;

    case (op)
      OP_RTYPE: begin
        dest      = rd;
        reg_write = 1'b1;
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_ADDU: alu_ctrl = ALU_ADDU;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_SUBU: alu_ctrl = ALU_SUBU;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_XOR:  alu_ctrl = ALU_XOR;
          FN_NOR:  alu_ctrl = ALU_NOR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          FN_SLTU: alu_ctrl = ALU_SLTU;
          FN_SLL:  begin alu_ctrl = ALU_SLL; shmt_sel = SHMT_INSTR; end
          FN_SRL:  begin alu_ctrl = ALU_SRL; shmt_sel = SHMT_INSTR; end
          FN_SRA:  begin alu_ctrl = ALU_SRA; shmt_sel = SHMT_INSTR; end
          FN_SLLV: begin alu_ctrl = ALU_SLL; shmt_sel = SHMT_BUSA;  end
          FN_SRLV: begin alu_ctrl = ALU_SRL; shmt_sel = SHMT_BUSA;  end
          FN_SRAV: begin alu_ctrl = ALU_SRA; shmt_sel = SHMT_BUSA;  end
          FN_JR:   begin alu_ctrl = ALU_ADD; reg_write = 1'b0;      end
          default: begin
            illegal   = 1'b1;
            reg_write = 1'b0;
            dest      = 5'd0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_LUI, OP_LW, OP_SW: begin
        dest      = rt;
        alu_src_b = SRCB_IMM;
        reg_write = (op != OP_SW);
        case (op)
          OP_ADDI:  alu_ctrl = ALU_ADD;
          OP_ADDIU: alu_ctrl = ALU_ADDU;
          OP_SLTI:  alu_ctrl = ALU_SLT;
          OP_SLTIU: alu_ctrl = ALU_SLTU;
          OP_ANDI:  begin alu_ctrl = ALU_AND; ext_sel = EXT_ZERO; end
          OP_ORI:   begin alu_ctrl = ALU_OR;  ext_sel = EXT_ZERO; end
          OP_XORI:  begin alu_ctrl = ALU_XOR; ext_sel = EXT_ZERO; end
          // ALU does the <<16; the stage only presents the raw halfword
          OP_LUI:   begin alu_ctrl = ALU_LUI; ext_sel = EXT_ZERO; end
          default:  alu_ctrl = ALU_ADD;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        alu_ctrl = ALU_SUB;
        dest     = rt;
      end
      OP_J: alu_ctrl = ALU_AND;
      OP_JAL: begin
        alu_ctrl  = ALU_ADD;
        reg_write = 1'b1;
        dest      = 5'd31;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID->EX issue register feeding the single-cycle ALU.
// Decodes Instr_ID, builds the immediate and pre-shifted rt value, and
// registers everything for one EX cycle with flush > stall > load priority.
// Ports:
//   CLK, Reset_L                    clock, async active-low reset
//   Instr_ID, Valid_ID              instruction word and its valid flag
//   BusA_ID, BusB_ID                rs / rt register values
//   Stall, Flush                    hold EX register / insert bubble
//   BusA_EX, BusB_EX, Shift_EX      registered operands and pre-shifted rt
//   ALUCtrl_EX, Shmt_EX             ALU code and shift amount
//   RegWrite_EX, Dest_EX            writeback enable and register
//   ALUSrcB_EX, Valid_EX, Illegal_EX
module alu_issue_stage
  import mips_alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          Reset_L,
  input  logic [31:0]   Instr_ID,
  input  logic          Valid_ID,
  input  logic [DW-1:0] BusA_ID,
  input  logic [DW-1:0] BusB_ID,
  input  logic          Stall,
  input  logic          Flush,
  output logic [DW-1:0] BusA_EX,
  output logic [DW-1:0] BusB_EX,
  output logic [DW-1:0] Shift_EX,
  output logic [3:0]    ALUCtrl_EX,
  output logic [4:0]    Shmt_EX,
  output logic          RegWrite_EX,
  output logic [4:0]    Dest_EX,
  output logic          ALUSrcB_EX,
  output logic          Valid_EX,
  output logic          Illegal_EX
);

  logic [3:0]    dec_alu_ctrl;
  logic [1:0]    dec_shmt_sel;
  logic          dec_alu_src_b;
  logic          dec_reg_write;
  logic [4:0]    dec_dest;
  logic          dec_ext_sel;
  logic          dec_illegal;

  logic [4:0]    shmt_id;
  logic [DW-1:0] imm32;
  logic [DW-1:0] busb_id;
  logic [DW-1:0] shift_id;
  ex_reg_t       ex_d;
  ex_reg_t       ex_q;

  alu_ctrl_decode u_decode (
    .instr     (Instr_ID),
    .alu_ctrl  (dec_alu_ctrl),
    .shmt_sel  (dec_shmt_sel),
    .alu_src_b (dec_alu_src_b),
    .reg_write (dec_reg_write),
    .dest      (dec_dest),
    .ext_sel   (dec_ext_sel),
    .illegal   (dec_illegal)
  );

  always_comb begin
    shmt_id = 5'd0;
    case (dec_shmt_sel)
      SHMT_INSTR: shmt_id = Instr_ID[10:6];
      SHMT_BUSA:  shmt_id = BusA_ID[4:0];
      default:    shmt_id = 5'd0;
    endcase
  end

  assign imm32 = (dec_ext_sel == EXT_SIGN) ? {{(DW-16){Instr_ID[15]}}, Instr_ID[15:0]}
                                           : {{(DW-16){1'b0}}, Instr_ID[15:0]};
  assign busb_id = (dec_alu_src_b == SRCB_IMM) ? imm32 : BusB_ID;

  // Always logical; the ALU supplies sign fill for SRA and uses its own
  // path for SLL, so only the right-shift result is precomputed here.
  assign shift_id = BusB_ID >> shmt_id;

  always_comb begin
    ex_d           = '0;
    ex_d.busa      = BusA_ID;
    ex_d.busb      = busb_id;
    ex_d.shift     = shift_id;
    ex_d.alu_ctrl  = dec_alu_ctrl;
    ex_d.shmt      = shmt_id;
    ex_d.reg_write = dec_reg_write;
    ex_d.dest      = dec_dest;
    ex_d.alu_src_b = dec_alu_src_b;
    ex_d.valid     = 1'b1;
    ex_d.illegal   = dec_illegal;
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      ex_q <= '0;
    end else if (Flush) begin
      ex_q <= '0;
    end else if (!Stall) begin
      ex_q <= Valid_ID ? ex_d : '0;
    end
  end

  assign BusA_EX     = ex_q.busa;
  assign BusB_EX     = ex_q.busb;
  assign Shift_EX    = ex_q.shift;
  assign ALUCtrl_EX  = ex_q.alu_ctrl;
  assign Shmt_EX     = ex_q.shmt;
  assign RegWrite_EX = ex_q.reg_write;
  assign Dest_EX     = ex_q.dest;
  assign ALUSrcB_EX  = ex_q.alu_src_b;
  assign Valid_EX    = ex_q.valid;
  assign Illegal_EX  = ex_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  typedef struct packed {
    logic [31:0] busa;
    logic [31:0] busb;
    logic [31:0] shift;
    logic [3:0]  alu;
    logic [4:0]  shmt;
    logic        rw;
    logic [4:0]  dest;
    logic        srcb;
    logic        valid;
    logic        ill;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic [31:0] Instr_ID = '0;
  logic        Valid_ID = 1'b0;
  logic [31:0] BusA_ID = '0;
  logic [31:0] BusB_ID = '0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic [31:0] BusA_EX, BusB_EX, Shift_EX;
  logic [3:0]  ALUCtrl_EX;
  logic [4:0]  Shmt_EX, Dest_EX;
  logic        RegWrite_EX, ALUSrcB_EX, Valid_EX, Illegal_EX;

  int checks = 0;
  int failures = 0;

  exp_t  sb_q[$];
  string name_q[$];

  alu_issue_stage #(.DW(32)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .Instr_ID(Instr_ID), .Valid_ID(Valid_ID),
    .BusA_ID(BusA_ID), .BusB_ID(BusB_ID), .Stall(Stall), .Flush(Flush),
    .BusA_EX(BusA_EX), .BusB_EX(BusB_EX), .Shift_EX(Shift_EX),
    .ALUCtrl_EX(ALUCtrl_EX), .Shmt_EX(Shmt_EX), .RegWrite_EX(RegWrite_EX),
    .Dest_EX(Dest_EX), .ALUSrcB_EX(ALUSrcB_EX), .Valid_EX(Valid_EX),
    .Illegal_EX(Illegal_EX)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] sh, input logic [3:0] alu,
                              input logic [4:0] shmt, input logic rw,
                              input logic [4:0] dest, input logic srcb,
                              input logic ill);
    exp_t e;
    e.busa = a; e.busb = b; e.shift = sh; e.alu = alu; e.shmt = shmt;
    e.rw = rw; e.dest = dest; e.srcb = srcb; e.valid = 1'b1; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t e;
    e.busa = BusA_EX; e.busb = BusB_EX; e.shift = Shift_EX; e.alu = ALUCtrl_EX;
    e.shmt = Shmt_EX; e.rw = RegWrite_EX; e.dest = Dest_EX; e.srcb = ALUSrcB_EX;
    e.valid = Valid_EX; e.ill = Illegal_EX;
    return e;
  endfunction

  task automatic compare(input string nm, input exp_t got, input exp_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got busa=%h busb=%h shift=%h alu=%b shmt=%0d rw=%b dest=%0d srcb=%b valid=%b ill=%b | want busa=%h busb=%h shift=%h alu=%b shmt=%0d rw=%b dest=%0d srcb=%b valid=%b ill=%b",
               nm, got.busa, got.busb, got.shift, got.alu, got.shmt, got.rw, got.dest,
               got.srcb, got.valid, got.ill, exp.busa, exp.busb, exp.shift, exp.alu,
               exp.shmt, exp.rw, exp.dest, exp.srcb, exp.valid, exp.ill);
    end
  endtask

  // Monitor: one EX-slot result per cycle, sampled mid-cycle
  initial begin
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) compare(name_q.pop_front(), actual(), sb_q.pop_front());
    end
  end

  // Drive one cycle of ID-stage inputs and post the expected EX contents
  task automatic step(input string nm, input logic [31:0] instr, input logic v,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic st, input logic fl, input exp_t e);
    Instr_ID = instr; Valid_ID = v; BusA_ID = a; BusB_ID = b;
    Stall = st; Flush = fl;
    @(posedge CLK);
    sb_q.push_back(e);
    name_q.push_back(nm);
    @(negedge CLK);
  endtask

  exp_t zero_e;
  exp_t add_e;

  initial begin
    zero_e = '0;
    add_e  = mk(32'd5, 32'd7, 32'd7, 4'b0010, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0);

    repeat (2) @(negedge CLK);
    compare("reset_state", actual(), zero_e);
    Reset_L = 1'b1;
    @(negedge CLK);

    step("add", 32'h00221820, 1, 32'd5, 32'd7, 0, 0, add_e);
    step("addi_neg1", 32'h2022FFFF, 1, 32'd10, 32'd20, 0, 0,
         mk(32'd10, 32'hFFFFFFFF, 32'h14, 4'b0010, 5'd0, 1, 5'd2, 1, 0));
    step("andi_zext", 32'h3022FFFF, 1, 32'd10, 32'd20, 0, 0,
         mk(32'd10, 32'h0000FFFF, 32'h14, 4'b0000, 5'd0, 1, 5'd2, 1, 0));
    step("srav", 32'h00221807, 1, 32'h24, 32'h80000000, 0, 0,
         mk(32'h24, 32'h80000000, 32'h08000000, 4'b1101, 5'd4, 1, 5'd3, 0, 0));
    step("sll_zero", 32'h00021800, 1, 32'h11, 32'hDEADBEEF, 0, 0,
         mk(32'h11, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0011, 5'd0, 1, 5'd3, 0, 0));
    step("lui", 32'h3C041234, 1, 32'd1, 32'd2, 0, 0,
         mk(32'd1, 32'h00001234, 32'd2, 4'b1110, 5'd0, 1, 5'd4, 1, 0));
    step("sw", 32'hAC220008, 1, 32'h100, 32'h55, 0, 0,
         mk(32'h100, 32'h8, 32'h55, 4'b0010, 5'd0, 0, 5'd2, 1, 0));
    step("srl_3", 32'h000228C2, 1, 32'd0, 32'h80000010, 0, 0,
         mk(32'd0, 32'h80000010, 32'h10000002, 4'b0100, 5'd3, 1, 5'd5, 0, 0));
    step("sllv_33", 32'h00273004, 1, 32'd33, 32'h100, 0, 0,
         mk(32'd33, 32'h100, 32'h80, 4'b0011, 5'd1, 1, 5'd6, 0, 0));
    step("sub", 32'h012A4022, 1, 32'd50, 32'd8, 0, 0,
         mk(32'd50, 32'd8, 32'd8, 4'b0110, 5'd0, 1, 5'd8, 0, 0));
    step("jal", 32'h0C000010, 1, 32'd4, 32'd9, 0, 0,
         mk(32'd4, 32'd9, 32'd9, 4'b0010, 5'd0, 1, 5'd31, 0, 0));
    step("slti_sext", 32'h2822FF80, 1, 32'd1, 32'd0, 0, 0,
         mk(32'd1, 32'hFFFFFF80, 32'd0, 4'b0111, 5'd0, 1, 5'd2, 1, 0));
    step("ori_zext", 32'h34228000, 1, 32'd1, 32'd3, 0, 0,
         mk(32'd1, 32'h00008000, 32'd3, 4'b0001, 5'd0, 1, 5'd2, 1, 0));

    step("stall_load", 32'h00221820, 1, 32'd5, 32'd7, 0, 0, add_e);
    step("stall_1", 32'h3022FFFF, 1, 32'd10, 32'd20, 1, 0, add_e);
    step("stall_2", 32'h3C041234, 1, 32'd1, 32'd2, 1, 0, add_e);
    step("stall_3", 32'hFC000000, 0, 32'd9, 32'd9, 1, 0, add_e);
    step("stall_flush", 32'h00221820, 1, 32'd5, 32'd7, 1, 1, zero_e);

    step("reload", 32'h00221820, 1, 32'd5, 32'd7, 0, 0, add_e);
    step("valid_low", 32'h00221820, 0, 32'd5, 32'd7, 0, 0, zero_e);
    step("reload2", 32'h00221820, 1, 32'd5, 32'd7, 0, 0, add_e);
    step("flush_only", 32'h00221820, 1, 32'd5, 32'd7, 0, 1, zero_e);

    step("illegal_op", 32'hFC221820, 1, 32'd5, 32'd7, 0, 0,
         mk(32'd5, 32'd7, 32'd7, 4'b0000, 5'd0, 0, 5'd0, 0, 1));
    step("illegal_funct", 32'h0022183F, 1, 32'd5, 32'd7, 0, 0,
         mk(32'd5, 32'd7, 32'd7, 4'b0000, 5'd0, 0, 5'd0, 0, 1));

    // Async reset while holding a stalled instruction
    step("pre_reset", 32'h00221820, 1, 32'd5, 32'd7, 0, 0, add_e);
    Stall = 1'b1;
    #2;
    Reset_L = 1'b0;
    #1;
    compare("async_reset", actual(), zero_e);
    @(negedge CLK);
    Reset_L = 1'b1;
    Stall = 1'b0;
    step("after_reset", 32'h00221820, 1, 32'd5, 32'd7, 0, 0, add_e);

    repeat (2) @(negedge CLK);
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected results never compared, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
